// File: rtl/nibble_serial_add_ctrl.sv
// Nibble-serial wide adder sequencer around a 4-bit ripple adder.
// Operands in, one nibble per cycle LSB first, wide sum and carry out.
module nibble_serial_add_ctrl #(
  parameter  int NIBBLES = 4,
  localparam int W       = 4 * NIBBLES,
  localparam int IW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  input  logic         in_ci,
  output logic [3:0]   add_a,
  output logic [3:0]   add_b,
  output logic         add_ci,
  input  logic [3:0]   add_sum,
  input  logic         add_co,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_co
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [NIBBLES-1:0][3:0] a_q, b_q, res_q;
  logic                    cy_q;
  logic [IW-1:0]           idx_q;
  logic                    last;

  assign last = (idx_q == IW'(NIBBLES - 1));

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      cy_q  <= 1'b0;
      idx_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q   <= in_a;
            b_q   <= in_b;
            cy_q  <= in_ci;
            idx_q <= '0;
            res_q <= '0;
          end
        end
        RUN: begin
          res_q[idx_q] <= add_sum;
          cy_q         <= add_co;
          if (!last) idx_q <= idx_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Adder inputs are forced to zero outside RUN so the adder sees no activity.
  always_comb begin
    add_a  = 4'h0;
    add_b  = 4'h0;
    add_ci = 1'b0;
    if (state_q == RUN) begin
      add_a  = a_q[idx_q];
      add_b  = b_q[idx_q];
      add_ci = cy_q;
    end
  end

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE) && !rst;
  assign out_sum   = res_q;
  assign out_co    = cy_q;

endmodule

// File: tb/tb_nibble_serial_add_ctrl.sv
// Directed bench for nibble_serial_add_ctrl, NIBBLES=4 and NIBBLES=1,
// with a behavioural 4-bit adder and scoreboard queues.
module tb_nibble_serial_add_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic        in_valid4 = 0, in_ready4, in_ci4 = 0;
  logic [15:0] in_a4 = 0, in_b4 = 0, out_sum4;
  logic [3:0]  add_a4, add_b4, add_sum4;
  logic        add_ci4, add_co4;
  logic        out_valid4, out_ready4 = 0, out_co4;

  logic        in_valid1 = 0, in_ready1, in_ci1 = 0;
  logic [3:0]  in_a1 = 0, in_b1 = 0, out_sum1;
  logic [3:0]  add_a1, add_b1, add_sum1;
  logic        add_ci1, add_co1;
  logic        out_valid1, out_ready1 = 0, out_co1;

  assign {add_co4, add_sum4} = {1'b0, add_a4} + {1'b0, add_b4} + 5'(add_ci4);
  assign {add_co1, add_sum1} = {1'b0, add_a1} + {1'b0, add_b1} + 5'(add_ci1);

  nibble_serial_add_ctrl #(.NIBBLES(4)) u4 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid4), .in_ready(in_ready4),
    .in_a(in_a4), .in_b(in_b4), .in_ci(in_ci4),
    .add_a(add_a4), .add_b(add_b4), .add_ci(add_ci4),
    .add_sum(add_sum4), .add_co(add_co4),
    .out_valid(out_valid4), .out_ready(out_ready4),
    .out_sum(out_sum4), .out_co(out_co4)
  );

  nibble_serial_add_ctrl #(.NIBBLES(1)) u1 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid1), .in_ready(in_ready1),
    .in_a(in_a1), .in_b(in_b1), .in_ci(in_ci1),
    .add_a(add_a1), .add_b(add_b1), .add_ci(add_ci1),
    .add_sum(add_sum1), .add_co(add_co1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .out_sum(out_sum1), .out_co(out_co1)
  );

  logic [16:0] q4[$];
  logic [4:0]  q1[$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept4(input logic [15:0] a, input logic [15:0] b,
                         input logic ci, input bit push);
    int n = 0;
    while (!in_ready4 && n < 50) begin
      tick();
      n++;
    end
    chk("accept_ready", 32'(in_ready4), 32'd1);
    in_valid4 = 1'b1;
    in_a4 = a;
    in_b4 = b;
    in_ci4 = ci;
    if (push) q4.push_back({1'b0, a} + {1'b0, b} + 17'(ci));
    tick();
    in_valid4 = 1'b0;
    in_a4 = 16'hdead;
    in_b4 = 16'hbeef;
    in_ci4 = 1'b1;
  endtask

  task automatic run4(output logic [3:0] cis);
    int lat = 0;
    cis = '0;
    while (!out_valid4 && lat < 20) begin
      if (lat < 4) cis[lat] = add_ci4;
      tick();
      lat++;
    end
    chk("latency4", 32'(lat), 32'd4);
  endtask

  task automatic drain4(input int hold, input bit poke);
    logic [16:0] first;
    logic [16:0] e;
    chk("done_valid", 32'(out_valid4), 32'd1);
    first = {out_co4, out_sum4};
    out_ready4 = 1'b0;
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        in_valid4 = 1'b1;
        in_a4 = 16'h5555;
        in_b4 = 16'h5555;
      end
      tick();
      chk("hold_valid", 32'(out_valid4), 32'd1);
      chk("hold_result", 32'({out_co4, out_sum4}), 32'(first));
      chk("hold_in_ready", 32'(in_ready4), 32'd0);
    end
    in_valid4 = 1'b0;
    total++;
    if (q4.size() == 0) begin
      bad++;
      $error("FAIL sb4_empty obs=%0h exp=none", {out_co4, out_sum4});
    end else begin
      e = q4.pop_front();
      assert ({out_co4, out_sum4} === e) else begin
        bad++;
        $error("FAIL sum4 obs=%0h exp=%0h", {out_co4, out_sum4}, e);
      end
    end
    out_ready4 = 1'b1;
    tick();
    out_ready4 = 1'b0;
    chk("after_valid", 32'(out_valid4), 32'd0);
    chk("after_in_ready", 32'(in_ready4), 32'd1);
  endtask

  initial begin
    logic [3:0]  cis;
    logic [4:0]  e1;
    int          acc[$];

    rst = 1'b1;
    tick();
    chk("rst_in_ready", 32'(in_ready4), 32'd0);
    chk("rst_out_valid", 32'(out_valid4), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("reset_in_ready", 32'(in_ready4), 32'd1);
    chk("reset_out_valid", 32'(out_valid4), 32'd0);
    chk("reset_sum", 32'({out_co4, out_sum4}), 32'd0);
    chk("reset_add", 32'({add_a4, add_b4, add_ci4}), 32'd0);

    accept4(16'h1234, 16'h1111, 1'b0, 1'b1);
    chk("run_in_ready", 32'(in_ready4), 32'd0);
    chk("run_add_a0", 32'(add_a4), 32'h4);
    run4(cis);
    chk("t1_sum", 32'(out_sum4), 32'h2345);
    drain4(0, 1'b0);

    accept4(16'hFFFF, 16'h0001, 1'b0, 1'b1);
    run4(cis);
    chk("t2_add_ci", 32'(cis), 32'b1110);
    drain4(0, 1'b0);

    accept4(16'hFFFF, 16'h0000, 1'b1, 1'b1);
    run4(cis);
    drain4(0, 1'b0);
    accept4(16'h8000, 16'h8000, 1'b0, 1'b1);
    run4(cis);
    chk("t3_co", 32'(out_co4), 32'd1);
    drain4(0, 1'b0);

    accept4(16'hA5C3, 16'h7E19, 1'b1, 1'b1);
    run4(cis);
    drain4(5, 1'b1);
    chk("t4_idle_add", 32'({add_a4, add_b4, add_ci4}), 32'd0);

    accept4(16'h1234, 16'h4321, 1'b1, 1'b0);
    tick();
    chk("t5_pre_rst_run", 32'(in_ready4), 32'd0);
    rst = 1'b1;
    #1;
    chk("t5_rst_in_ready", 32'(in_ready4), 32'd0);
    chk("t5_rst_out_valid", 32'(out_valid4), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("t5_in_ready", 32'(in_ready4), 32'd1);
    chk("t5_out_valid", 32'(out_valid4), 32'd0);
    chk("t5_out_sum", 32'({out_co4, out_sum4}), 32'd0);
    accept4(16'h0F0F, 16'hF0F0, 1'b0, 1'b1);
    run4(cis);
    drain4(0, 1'b0);

    for (int k = 0; k < 3; k++) begin
      accept4(16'($urandom), 16'($urandom), 1'($urandom), 1'b1);
      run4(cis);
      drain4(k, 1'b0);
    end

    in_a1 = 4'hF;
    in_b1 = 4'h1;
    in_ci1 = 1'b1;
    in_valid1 = 1'b1;
    chk("n1_ready", 32'(in_ready1), 32'd1);
    tick();
    in_valid1 = 1'b0;
    chk("n1_run_not_valid", 32'(out_valid1), 32'd0);
    tick();
    chk("n1_valid_1edge", 32'(out_valid1), 32'd1);
    chk("n1_sum", 32'({out_co1, out_sum1}), 32'h11);
    out_ready1 = 1'b1;
    tick();
    chk("n1_back_idle", 32'(in_ready1), 32'd1);

    in_valid1 = 1'b1;
    for (int c = 0; c < 13; c++) begin
      if (out_valid1) begin
        total++;
        if (q1.size() == 0) begin
          bad++;
          $error("FAIL sb1_empty obs=%0h exp=none", {out_co1, out_sum1});
        end else begin
          e1 = q1.pop_front();
          assert ({out_co1, out_sum1} === e1) else begin
            bad++;
            $error("FAIL sum1 obs=%0h exp=%0h", {out_co1, out_sum1}, e1);
          end
        end
      end
      if (in_ready1) begin
        acc.push_back(c);
        q1.push_back({1'b0, in_a1} + {1'b0, in_b1} + 5'(in_ci1));
      end
      tick();
      if (acc.size() > 0 && acc[acc.size()-1] == c) begin
        in_a1 = 4'($urandom);
        in_b1 = 4'($urandom);
        in_ci1 = 1'($urandom);
      end
    end
    in_valid1 = 1'b0;
    chk("n1_accepts", 32'(acc.size()), 32'd5);
    for (int i = 1; i < acc.size(); i++)
      chk("n1_spacing", 32'(acc[i] - acc[i-1]), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
